fir_sample_feeder: RTL and testbench
====================================

Name: fir_sample_feeder

Overview:
- Input-side buffer directly upstream of the FIR top level.
- Accepts 32-bit samples from the audio source over a valid/ready handshake and stores them in a small circular FIFO.
- Returns one sample on data_out for each read request from the FIR (driven by the FIR's start_toread).
- Drives the FIR hold input while the buffer is priming or has run dry, so the filter never consumes a stale or missing sample.

Parameters:
DATA_W, 32, sample width; matches FIR data_in.
DEPTH, 8, FIFO entries; must be a power of two.
ADDR_W, 3, log2(DEPTH); pointer width.
PREFILL, 4, occupancy required before hold is released; legal range 1..DEPTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous clear of FIFO contents; pulse on filter_select or band change.
in_data  input  DATA_W  sample from the source.
in_valid  input  1  in_data is valid.
in_ready  output  1  FIFO can accept a sample this cycle.
rd_req  input  1  FIR requests the next sample; connect to start_toread.
data_out  output  DATA_W  registered sample to FIR data_in.
data_valid  output  1  one-cycle pulse: data_out was updated this cycle.
hold  output  1  to FIR hold; 1 = FIR must stall.
level  output  ADDR_W+1  current occupancy, 0..DEPTH.
underflow_cnt  output  8  saturating count of starved read requests.

Behaviour:
- Reset (asynchronous, active-high) applies immediately regardless of clk:
  - wr_ptr = 0, rd_ptr = 0, count = 0, state = FILL.
  - data_out = 0, data_valid = 0, hold = 1, underflow_cnt = 0.
- in_ready = (count != DEPTH), decoded from registered count.
- Push: when in_valid && in_ready, mem[wr_ptr] <= in_data and wr_ptr increments, wrapping DEPTH-1 -> 0.
- Push is not allowed when full, even if a pop occurs in the same cycle.
- Pop: only in state STREAM, when rd_req && count != 0.
  - data_out <= mem[rd_ptr] and rd_ptr increments with wrap.
  - data_valid = 1 in the cycle after the rd_req edge (1-cycle latency).
  - data_valid is 0 in all other cycles.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - A push and pop to the same entry cannot occur: pop reads only occupied entries.
- count = pushes - pops; it never exceeds DEPTH and never underflows.
- level = count.
- States:
  - FILL: hold = 1; rd_req is ignored (no pop, no underflow count). Go to STREAM when count >= PREFILL, with count evaluated post-update in the same cycle.
  - STREAM: hold = 0. If rd_req && count == 0, go to STARVED; underflow_cnt increments, saturating at 255; data_out keeps its last value; data_valid = 0.
  - STARVED: hold = 1; rd_req is ignored. Go to FILL on the next cycle.
- hold is a registered output decoded from the next state, so it changes in the same cycle as the state.
- flush, synchronous:
  - Pointers and count are cleared and state = FILL; hold = 1 from the next cycle.
  - data_out is retained.
  - underflow_cnt is retained; only reset clears it.
  - flush has priority over push and pop in the same cycle; the sample being pushed is discarded.
- Reset asserted mid-stream: all state is lost and the block restarts in FILL.
- The FIR must honour hold. Any rd_req arriving while hold = 1 is dropped and is not queued.

Test Plan:
- Reset, then push 0x00000001..0x00000004 on consecutive cycles. Required:
  - hold = 1 while level < 4.
  - hold = 0 in the cycle after the 4th push.
  - level = 4.
- From that state, pulse rd_req for 4 single cycles. Required:
  - data_out = 1, 2, 3, 4 in order, each with a one-cycle data_valid pulse one cycle after its request.
  - level ends at 0 and hold stays 0.
- With level = 0 in STREAM, assert rd_req. Required:
  - underflow_cnt = 1; state goes STARVED then FILL; hold = 1.
  - data_out stays 4 and data_valid = 0.
  - After 4 further pushes, hold returns to 0.
- Push 9 samples with no reads. Required:
  - in_ready drops after the 8th push and the 9th sample is refused.
  - level = 8.
  - The next 8 reads return samples 1..8, proving wrap-around.
- With level = 4, assert push and rd_req in the same cycle. Required:
  - level stays 4.
  - The oldest sample is output.
  - The pushed sample is read out 4 reads later.
- At level = 6, assert flush together with in_valid. Required:
  - level = 0 and hold = 1 next cycle; the pushed sample is discarded.
  - underflow_cnt is retained.
  - Separately: assert reset mid-read and confirm data_out = 0 and data_valid = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fir_sample_feeder.sv
// Input-side sample buffer for the FIR: circular FIFO with prefill gating
// and a registered hold that stalls the filter while priming or starved.
module fir_sample_feeder #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 3,
   parameter int PREFILL = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              rd_req,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              hold,
   output logic [ADDR_W:0]   level,
   output logic [7:0]        underflow_cnt
);

   typedef enum logic [1:0] {
      S_FILL,
      S_STREAM,
      S_STARVED
   } state_t;

   localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] C_PRE  = (ADDR_W+1)'(PREFILL);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   state_t            r_state;
   logic [DATA_W-1:0] r_data_out;
   logic              r_data_valid;
   logic              r_hold;
   logic [7:0]        r_uflow;

   state_t            w_state_nxt;
   logic [ADDR_W:0]   w_count_nxt;
   logic              w_in_ready;
   logic              w_push;
   logic              w_pop;
   logic              w_starve;
   logic              w_streaming;

   assign w_in_ready  = (r_count != C_FULL);
   assign w_streaming = (r_state == S_STREAM);

   // flush wins over both sides; a sample offered alongside it is dropped
   assign w_push   = in_valid && w_in_ready && !flush;
   assign w_pop    = w_streaming && rd_req && (r_count != '0) && !flush;
   assign w_starve = w_streaming && rd_req && (r_count == '0) && !flush;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - 1'b1;
      end
      if (flush) begin
         w_count_nxt = '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FILL: begin
            if (w_count_nxt >= C_PRE) begin
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (w_starve) begin
               w_state_nxt = S_STARVED;
            end
         end
         S_STARVED: begin
            w_state_nxt = S_FILL;
         end
         default: begin
            w_state_nxt = S_FILL;
         end
      endcase
      if (flush) begin
         w_state_nxt = S_FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_state  <= S_FILL;
      end else begin
         r_count <= w_count_nxt;
         r_state <= w_state_nxt;
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end
      end
   end

   // hold follows the next state so it moves in step with r_state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_hold       <= 1'b1;
         r_uflow      <= '0;
      end else begin
         r_data_valid <= w_pop;
         r_hold       <= (w_state_nxt != S_STREAM);
         if (w_pop) begin
            r_data_out <= r_mem[r_rd_ptr];
         end
         if (w_starve && (r_uflow != 8'hFF)) begin
            r_uflow <= r_uflow + 1'b1;
         end
      end
   end

   assign in_ready      = w_in_ready;
   assign data_out      = r_data_out;
   assign data_valid    = r_data_valid;
   assign hold          = r_hold;
   assign level         = r_count;
   assign underflow_cnt = r_uflow;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: prefill, reads, starvation,
// full/wrap, concurrent push+pop, flush and asynchronous reset.
module tb_fir_sample_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        rd_req;
   logic [31:0] data_out;
   logic        data_valid;
   logic        hold;
   logic [3:0]  level;
   logic [7:0]  underflow_cnt;

   int errors = 0;
   int checks = 0;

   fir_sample_feeder #(
      .DATA_W(32), .DEPTH(8), .ADDR_W(3), .PREFILL(4)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .rd_req(rd_req), .data_out(data_out), .data_valid(data_valid),
      .hold(hold), .level(level), .underflow_cnt(underflow_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic rd(input logic [31:0] exp, input string tag);
      rd_req = 1'b1;
      tick();
      chk({tag, "_dv"}, {31'd0, data_valid}, 32'd1);
      chk({tag, "_do"}, data_out, exp);
      rd_req = 1'b0;
      tick();
      chk({tag, "_dv0"}, {31'd0, data_valid}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_data = '0;
      in_valid = 1'b0; rd_req = 1'b0;
      #12;
      chk("rst_hold", {31'd0, hold}, 32'd1);
      chk("rst_level", {28'd0, level}, 32'd0);
      chk("rst_do", data_out, 32'd0);
      chk("rst_dv", {31'd0, data_valid}, 32'd0);
      chk("rst_uf", {24'd0, underflow_cnt}, 32'd0);
      chk("rst_rdy", {31'd0, in_ready}, 32'd1);
      reset = 1'b0;
      tick();

      // prefill 1..4
      for (int k = 1; k <= 4; k++) begin
         push(32'(k));
         chk($sformatf("pf_lvl%0d", k), {28'd0, level}, 32'(k));
         chk($sformatf("pf_hold%0d", k), {31'd0, hold},
             (k < 4) ? 32'd1 : 32'd0);
      end

      // drain
      for (int k = 1; k <= 4; k++) begin
         rd(32'(k), $sformatf("rd%0d", k));
      end
      chk("drain_lvl", {28'd0, level}, 32'd0);
      chk("drain_hold", {31'd0, hold}, 32'd0);

      // starve
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("sv_uf", {24'd0, underflow_cnt}, 32'd1);
      chk("sv_hold", {31'd0, hold}, 32'd1);
      chk("sv_dv", {31'd0, data_valid}, 32'd0);
      chk("sv_do", data_out, 32'd4);
      tick();
      chk("fill_hold", {31'd0, hold}, 32'd1);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("fill_rd_ign_dv", {31'd0, data_valid}, 32'd0);
      chk("fill_rd_ign_uf", {24'd0, underflow_cnt}, 32'd1);
      for (int k = 5; k <= 8; k++) begin
         push(32'(k));
         chk($sformatf("rf_hold%0d", k), {31'd0, hold},
             (k < 8) ? 32'd1 : 32'd0);
      end
      for (int k = 5; k <= 8; k++) begin
         rd(32'(k), $sformatf("rd%0d", k));
      end

      // fill to full
      for (int k = 1; k <= 9; k++) begin
         chk($sformatf("full_rdy%0d", k), {31'd0, in_ready},
             (k <= 8) ? 32'd1 : 32'd0);
         push(32'(k));
      end
      chk("full_lvl", {28'd0, level}, 32'd8);
      for (int k = 1; k <= 8; k++) begin
         rd(32'(k), $sformatf("wrap%0d", k));
      end
      chk("wrap_lvl", {28'd0, level}, 32'd0);

      // concurrent push + pop
      for (int k = 0; k < 4; k++) begin
         push(32'hA0 + 32'(k));
      end
      in_valid = 1'b1;
      in_data  = 32'hA4;
      rd_req   = 1'b1;
      tick();
      in_valid = 1'b0;
      rd_req   = 1'b0;
      chk("pp_lvl", {28'd0, level}, 32'd4);
      chk("pp_do", data_out, 32'hA0);
      chk("pp_dv", {31'd0, data_valid}, 32'd1);
      tick();
      for (int k = 1; k <= 4; k++) begin
         rd(32'hA0 + 32'(k), $sformatf("pp_rd%0d", k));
      end

      // flush with concurrent push
      for (int k = 0; k < 6; k++) begin
         push(32'h60 + 32'(k));
      end
      chk("fl_pre_lvl", {28'd0, level}, 32'd6);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h66;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_lvl", {28'd0, level}, 32'd0);
      chk("fl_hold", {31'd0, hold}, 32'd1);
      chk("fl_uf", {24'd0, underflow_cnt}, 32'd1);
      chk("fl_do", data_out, 32'hA4);
      for (int k = 0; k < 4; k++) begin
         push(32'h70 + 32'(k));
      end
      chk("fl_rf_hold", {31'd0, hold}, 32'd0);
      rd(32'h70, "fl_rd0");

      // asynchronous reset mid-read
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("ar_pre_dv", {31'd0, data_valid}, 32'd1);
      chk("ar_pre_do", data_out, 32'h71);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_do", data_out, 32'd0);
      chk("ar_dv", {31'd0, data_valid}, 32'd0);
      chk("ar_hold", {31'd0, hold}, 32'd1);
      chk("ar_lvl", {28'd0, level}, 32'd0);
      chk("ar_uf", {24'd0, underflow_cnt}, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
